// File: rtl/video_config_pkg.sv
// video_config_pkg: definitions shared by the video-mode configuration
// transmitter and receiver.
//   VideoModeSel    requested video mode (VGA, 720P, 1080P)
//   CODE_*          one-hot codes carried on configuration byte bits [2:0]
//   SEQ_BIT         position of the sequence-toggle bit
//   tx_state_e      transmitter FSM states
//   encode()        VideoModeSel -> one-hot code (single shared definition)
//   to_sel()        raw 2-bit request -> VideoModeSel (3 maps to VGA)
package video_config_pkg;

  typedef enum logic [1:0] {
    VGA        = 2'd0,
    MODE_720P  = 2'd1,
    MODE_1080P = 2'd2
  } VideoModeSel;

  localparam logic [2:0] CODE_VGA   = 3'b001;
  localparam logic [2:0] CODE_720P  = 3'b010;
  localparam logic [2:0] CODE_1080P = 3'b100;
  localparam int         SEQ_BIT    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2
  } tx_state_e;

  function automatic logic [2:0] encode(VideoModeSel m);
    case (m)
      MODE_720P:  return CODE_720P;
      MODE_1080P: return CODE_1080P;
      default:    return CODE_VGA;
    endcase
  endfunction

  // The unused request value 3 falls back to VGA.
  function automatic VideoModeSel to_sel(logic [1:0] r);
    case (r)
      2'd1:    return MODE_720P;
      2'd2:    return MODE_1080P;
      default: return VGA;
    endcase
  endfunction

endpackage

// File: rtl/video_config_tx_timer.sv
// video_config_tx_timer: loadable down-counter with a zero flag.
//   clock, reset_n  clock and asynchronous active-low reset
//   load, load_val  load the counter (takes priority over counting)
//   zero            counter is 0; the counter stops there until reloaded
module video_config_tx_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/video_config_tx.sv
// video_config_tx: transmitter for the 8-bit video-mode configuration byte.
// A request accepted over valid/ready first drives the new one-hot mode on
// bits [2:0] for SETUP_CYCLES, then flips the bit-7 sequence toggle and holds
// the byte for HOLD_CYCLES before the next transfer may begin.
//   clock, reset_n   clock, asynchronous active-low reset
//   mode_req         0 VGA, 1 720P, 2 1080P, 3 treated as VGA
//   req_valid/ready  request handshake
//   data_out         {toggle, 4'b0, one-hot mode}
//   busy             transfer in SETUP or HOLD
//   done             one-cycle pulse at transfer completion
//   current_mode     mode most recently fully transmitted
// Optional feature: VIDEO_CONFIG_TX_COALESCE_EN -- req_ready stays high and
// requests arriving while busy collapse into one last-wins pending slot.
module video_config_tx
  import video_config_pkg::*;
#(
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] mode_req,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] current_mode
);

  localparam int MAX_CYC = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

  tx_state_e   state_q, state_d;
  logic [2:0]  code_q, code_d;
  logic        seq_q, seq_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  VideoModeSel cur_q, cur_d;
  VideoModeSel infl_q, infl_d;     // mode of the transfer in flight

  logic          tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
  logic          start;
  VideoModeSel   start_sel;

`ifdef VIDEO_CONFIG_TX_COALESCE_EN
  logic        pend_vld_q, pend_vld_d;
  VideoModeSel pend_q, pend_d;
`endif

  video_config_tx_timer #(.W(CW)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    seq_d     = seq_q;
    done_d    = 1'b0;
    cur_d     = cur_q;
    infl_d    = infl_q;
    tmr_load  = 1'b0;
    tmr_val   = SETUP_LD;
    start     = 1'b0;
    start_sel = to_sel(mode_req);
`ifdef VIDEO_CONFIG_TX_COALESCE_EN
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (state_q != IDLE && req_valid) begin
      pend_vld_d = 1'b1;
      pend_d     = to_sel(mode_req);
    end
`endif

    case (state_q)
      // req_ready is always high in IDLE, so req_valid alone is an accept.
      IDLE: if (req_valid) start = 1'b1;
      SETUP: if (tmr_zero) begin
        seq_d    = ~seq_q;
        tmr_load = 1'b1;
        tmr_val  = HOLD_LD;
        state_d  = HOLD;
      end
      HOLD: if (tmr_zero) begin
        done_d  = 1'b1;
        cur_d   = infl_q;
        state_d = IDLE;
`ifdef VIDEO_CONFIG_TX_COALESCE_EN
        // A request arriving this very cycle is newer than the stored one.
        if (req_valid) begin
          start = 1'b1;
        end else if (pend_vld_q) begin
          start     = 1'b1;
          start_sel = pend_q;
        end
        pend_vld_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Mode bits change here; the toggle only flips after SETUP expires.
    if (start) begin
      infl_d   = start_sel;
      code_d   = encode(start_sel);
      tmr_load = 1'b1;
      tmr_val  = SETUP_LD;
      state_d  = SETUP;
    end

    busy_d = (state_d != IDLE);
`ifdef VIDEO_CONFIG_TX_COALESCE_EN
    ready_d = 1'b1;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= CODE_VGA;
      seq_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      cur_q   <= VGA;
      infl_q  <= VGA;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      cur_q   <= cur_d;
      infl_q  <= infl_d;
    end
  end

`ifdef VIDEO_CONFIG_TX_COALESCE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_q <= 1'b0;
      pend_q     <= VGA;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end
`endif

  always_comb begin
    data_out          = '0;
    data_out[2:0]     = code_q;
    data_out[SEQ_BIT] = seq_q;
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign current_mode = cur_q;

endmodule
